single_port_ram_be: RTL and testbench
=====================================

// Module: single_port_ram_be
// PURPOSE
//  Parametrised single-port synchronous RAM with per-byte write enables.
//  Configurable read latency (1 or 2 cycles) and explicit read-data valid.
//  Hardware init sweep after reset or clr; requests are blocked (ready=0) until the sweep completes.
//  Out-of-range addresses are flagged for MEM_DEPTH < 2**ADDR_WIDTH.
//  Drop-in scratch/register store behind a valid/ready requester.
// PARAMETERS
//  ADDR_WIDTH  5             address bits
//  DATA_WIDTH  32            word width; multiple of 8
//  MEM_DEPTH   32            words implemented; 1..2**ADDR_WIDTH
//  RD_LATENCY  1             accept-to-dout cycles; 1 or 2 only
//  INIT_VALUE  {DATA_WIDTH{1'b0}}  word written by the init sweep
// PORTS
//  clk       in   1             single clock, rising edge
//  rst       in   1             synchronous reset, active-high
//  clr       in   1             re-run init sweep; 1-cycle pulse suffices
//  en        in   1             request enable
//  valid     in   1             request valid
//  wr_rd     in   1             1=write, 0=read
//  addr      in   ADDR_WIDTH    word address
//  din       in   DATA_WIDTH    write data
//  be        in   DATA_WIDTH/8  byte enables; be[i] gates din[8i+7:8i]
//  ready     out  1             1 = can accept a request this cycle
//  dout      out  DATA_WIDTH    read data; held between reads
//  rd_valid  out  1             1-cycle pulse: dout carries a new read result
//  error     out  1             1-cycle pulse: out-of-range request
// BEHAVIOUR
//  - Reset (rst=1 at edge) clears outputs: ready=0, dout=0, rd_valid=0, error=0.
//    Reset also sets state=ST_INIT, sweep counter=0 and flushes the read pipe.
//    Memory contents are only changed by the sweep.
//  - ST_INIT: writes INIT_VALUE to mem[cnt] each cycle, cnt 0..MEM_DEPTH-1.
//    After the write at cnt=MEM_DEPTH-1, moves to ST_IDLE; ready=1 from the next cycle.
//    Sweep length is exactly MEM_DEPTH cycles.
//    Requests in ST_INIT are ignored: no write, no rd_valid, no error.
//  - clr=1 in ST_IDLE: at that edge, ready drops, cnt=0, state=ST_INIT.
//    A request in the same cycle is dropped; clr wins.
//    clr during ST_INIT restarts the sweep at 0. rst during the sweep also restarts it.
//  - Accept = ready & en & valid. At most one request per cycle; no backpressure in ST_IDLE.
//  - Accepted write, addr<MEM_DEPTH: each byte i with be[i]=1 updates at this edge; other bytes are kept.
//    be=0 writes nothing and raises no error. A write never changes dout.
//  - Accepted read, addr<MEM_DEPTH: dout and rd_valid update RD_LATENCY edges after accept.
//    RD_LATENCY=2 adds an output register stage. Back-to-back reads are fully pipelined.
//    A read following a write to the same address (next cycle or later) returns the written data.
//  - Accepted request, addr>=MEM_DEPTH: memory unchanged; error=1 for one cycle after accept.
//    A read with out-of-range address gives no rd_valid, and dout holds.
//  - In-flight reads at rst are discarded, with no rd_valid. In-flight reads at clr still complete.
//  - en=0 or valid=0: no operation; dout holds its last value.
// STRUCTURE
//  - Package single_port_ram_pkg holds:
//      state typedef {ST_INIT, ST_IDLE};
//      WR=1'b1 / RD=1'b0 constants;
//      function in_range(addr, depth).
//  - Sub-module sp_ram_array: the storage array.
//      Ports: clk, we, wbe, waddr, wdata, raddr, rdata. Registered read, 1 cycle.
//      Byte-enable mask. No reset on storage.
//  - Top level holds: init FSM and sweep counter; accept/range logic; mux of sweep vs. user write;
//    optional 2nd dout stage; rd_valid/error shift pipe of depth RD_LATENCY.
// TESTING
//  1. rst 1 cycle, MEM_DEPTH=32 -> ready=0 for exactly 32 cycles, then 1.
//     Read every addr -> dout=0x00000000.
//  2. Write addr=2, din=0x2A2A2A2A, be=4'hF; next cycle read addr=2.
//     -> rd_valid 1 cycle later (2 for RD_LATENCY=2), dout=0x2A2A2A2A.
//  3. Write addr=4, 0x4A4A4A4A, be=F; then write addr=4, 0x11223344, be=4'b0101; read addr=4 -> 0x4A224A44.
//  4. MEM_DEPTH=24: write addr=5'd30 -> error pulses 1 cycle, rd_valid=0.
//     Read addr=30 -> error=1 and dout unchanged. Write with be=0 -> error=0.
//  5. Back-to-back reads of addr 3,4,5 holding 0x3A3A3A3A, 0x4A4A4A4A, 0x5A5A5A5A:
//     -> three consecutive rd_valid with those values, in order.
//  6. Write addr=8, 0x6A6A6A6A; pulse clr mid-stream; read issued during sweep -> ignored.
//     After ready returns, read addr=8 -> 0x00000000.
//     rst asserted with a read in flight -> no rd_valid.

Source files
------------

// File: rtl/single_port_ram_pkg.sv
// rtl/single_port_ram_pkg.sv - shared types, constants and helpers for single_port_ram_be
// Purpose : state encoding of the init/idle controller, request-direction
//           constants and the address range check used by the top level.
// Ports   : none (package).
package single_port_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    // True when a word address falls inside the implemented depth.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/sp_ram_array.sv
// rtl/sp_ram_array.sv - byte-maskable storage array with registered read
// Purpose : MEM_DEPTH x DATA_WIDTH storage, no reset on contents.
// Ports   : clk   - rising-edge clock
//           we    - write strobe
//           wbe   - per-byte write mask, wbe[i] gates wdata[8i+7:8i]
//           waddr - write word address
//           wdata - write data
//           raddr - read word address, sampled every cycle
//           rdata - registered read data, valid the cycle after raddr
module sp_ram_array #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 32
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        // Free-running read: the top level decides when the value is consumed.
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/single_port_ram_be.sv
// rtl/single_port_ram_be.sv - single-port RAM with byte enables, init sweep and read-valid
// Purpose : valid/ready scratch store. After rst or clr the whole array is swept
//           to INIT_VALUE (MEM_DEPTH cycles, ready=0). Reads return after
//           RD_LATENCY cycles with a rd_valid pulse; out-of-range requests pulse error.
// Ports   : clk, rst (sync, active-high), clr (restart sweep)
//           en, valid, wr_rd, addr, din, be - request
//           ready    - request can be accepted this cycle
//           dout     - read data, held between reads
//           rd_valid - one-cycle pulse marking a new dout
//           error    - one-cycle pulse after an out-of-range accepted request
module single_port_ram_be
    import single_port_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 32,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    valid,
    input  logic                    wr_rd,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    rd_valid,
    output logic                    error
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    ready_q;
    logic                    error_q;
    logic [RD_LATENCY-1:0]   rv_q;
    logic [DATA_WIDTH-1:0]   dout_q;

    logic                    acc_d;
    logic                    addr_ok_d;
    logic                    rd_acc_d;
    logic                    sweep_d;

    logic                    mem_we;
    logic [NBYTES-1:0]       mem_wbe;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    // ready_q is only ever 1 in ST_IDLE; clr in the same cycle kills the request.
    always_comb begin
        sweep_d   = (state_q == ST_INIT);
        addr_ok_d = in_range(32'(addr), MEM_DEPTH);
        acc_d     = ready_q & en & valid & ~clr;
        rd_acc_d  = acc_d & (wr_rd == RD) & addr_ok_d;

        mem_we    = sweep_d | (acc_d & (wr_rd == WR) & addr_ok_d);
        mem_wbe   = sweep_d ? {NBYTES{1'b1}} : be;
        mem_waddr = sweep_d ? cnt_q : addr;
        mem_wdata = sweep_d ? INIT_VALUE : din;
    end

    sp_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .wbe   (mem_wbe),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rv_q    <= '0;
            dout_q  <= '0;
        end else begin
            error_q <= acc_d & ~addr_ok_d;

            // Read-valid shift pipe; in-flight reads survive clr.
            rv_q[0] <= rd_acc_d;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rv_q[i] <= rv_q[i-1];
            end

            // rv_q[0] marks the cycle in which mem_rdata holds the accepted word.
            if (rv_q[0]) begin
                dout_q <= mem_rdata;
            end

            case (state_q)
                ST_INIT: begin
                    if (clr) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state_q <= ST_INIT;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // With one cycle of latency the array register is the output stage, so dout
    // shows mem_rdata during the valid cycle and the captured copy afterwards.
    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign dout = rv_q[0] ? mem_rdata : dout_q;
        end else begin : g_lat2
            assign dout = dout_q;
        end
    endgenerate

    assign ready    = ready_q;
    assign rd_valid = rv_q[RD_LATENCY-1];
    assign error    = error_q;

endmodule

// File: tb/tb_single_port_ram_be.sv
// tb/tb_single_port_ram_be.sv - self-checking bench for single_port_ram_be (latency 1 and 2)
module tb_single_port_ram_be;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          en = 1'b0;
    logic          valid = 1'b0;
    logic          wr_rd = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic [3:0]    be = '0;

    logic          ready1, rv1, err1;
    logic [DW-1:0] dout1;
    logic          ready2, rv2, err2;
    logic [DW-1:0] dout2;

    always #5 clk = ~clk;

    single_port_ram_be #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MEM_DEPTH (DEPTH), .RD_LATENCY (1), .INIT_VALUE ('0)
    ) dut1 (
        .clk (clk), .rst (rst), .clr (clr), .en (en), .valid (valid), .wr_rd (wr_rd),
        .addr (addr), .din (din), .be (be),
        .ready (ready1), .dout (dout1), .rd_valid (rv1), .error (err1)
    );

    single_port_ram_be #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MEM_DEPTH (DEPTH), .RD_LATENCY (2), .INIT_VALUE ('0)
    ) dut2 (
        .clk (clk), .rst (rst), .clr (clr), .en (en), .valid (valid), .wr_rd (wr_rd),
        .addr (addr), .din (din), .be (be),
        .ready (ready2), .dout (dout2), .rd_valid (rv2), .error (err2)
    );

    // Reference model: word array plus the observable outputs expected after each edge.
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_ready = 1'b0;
    int            m_left  = 0;
    logic [DW-1:0] m_dout1 = '0;
    logic [DW-1:0] m_dout2 = '0;
    logic          m_p2 = 1'b0;
    logic [DW-1:0] m_p2_data = '0;
    logic          e_rv1, e_rv2, e_err;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic cl, input logic e, input logic v,
                         input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] b);
        e_rv1 = 1'b0;
        e_rv2 = 1'b0;
        e_err = 1'b0;
        if (r) begin
            m_ready = 1'b0;
            m_left  = DEPTH;
            m_p2    = 1'b0;
            m_dout1 = '0;
            m_dout2 = '0;
        end else begin
            if (m_p2) begin
                e_rv2   = 1'b1;
                m_dout2 = m_p2_data;
                m_p2    = 1'b0;
            end
            if (cl) begin
                m_ready = 1'b0;
                m_left  = DEPTH;
            end else if (!m_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
                end
            end else if (e && v) begin
                if (int'(a) >= DEPTH) begin
                    e_err = 1'b1;
                end else if (w) begin
                    for (int i = 0; i < 4; i++)
                        if (b[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
                end else begin
                    e_rv1     = 1'b1;
                    m_dout1   = m_mem[a];
                    m_p2      = 1'b1;
                    m_p2_data = m_mem[a];
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic cl, input logic e, input logic v,
                        input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] b);
        @(negedge clk);
        rst = r; clr = cl; en = e; valid = v; wr_rd = w; addr = a; din = d; be = b;
        model(r, cl, e, v, w, a, d, b);
        @(posedge clk);
        #1;
        cyc++;
        chk("ready1", 32'(ready1), 32'(m_ready));
        chk("ready2", 32'(ready2), 32'(m_ready));
        chk("rd_valid1", 32'(rv1), 32'(e_rv1));
        chk("rd_valid2", 32'(rv2), 32'(e_rv2));
        chk("error1", 32'(err1), 32'(e_err));
        chk("error2", 32'(err2), 32'(e_err));
        chk("dout1", dout1, m_dout1);
        chk("dout2", dout2, m_dout2);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a, d, b);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, a, '0, '0);
    endtask

    initial begin
        int zero_cycles;
        logic r, cl, e, v, w;
        logic [AW-1:0] a;

        // Reset, then count the sweep length directly on ready.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        zero_cycles = (ready1 == 1'b0) ? 1 : 0;
        for (int i = 0; i < DEPTH + 4 && ready1 !== 1'b1; i++) begin
            idle();
            if (ready1 !== 1'b1) zero_cycles++;
        end
        chk("sweep_len", 32'(zero_cycles), 32'(DEPTH));

        for (int i = 0; i < DEPTH; i++) rd(AW'(i));
        idle();
        idle();

        // Write then read back.
        wr(5'd2, 32'h2A2A2A2A, 4'hF);
        rd(5'd2);
        chk("rd2_const", dout1, 32'h2A2A2A2A);
        idle();
        chk("rd2_const_l2", dout2, 32'h2A2A2A2A);

        // Byte-masked overwrite.
        wr(5'd4, 32'h4A4A4A4A, 4'hF);
        wr(5'd4, 32'h11223344, 4'b0101);
        rd(5'd4);
        chk("merge_const", dout1, 32'h4A224A44);
        idle();

        // Out-of-range requests and an empty byte mask.
        wr(5'd30, 32'hDEADBEEF, 4'hF);
        rd(5'd30);
        wr(5'd31, 32'h0BADF00D, 4'h0);
        wr(5'd1, 32'hFFFFFFFF, 4'h0);
        rd(5'd1);
        idle();

        // Back-to-back reads.
        wr(5'd3, 32'h3A3A3A3A, 4'hF);
        wr(5'd4, 32'h4A4A4A4A, 4'hF);
        wr(5'd5, 32'h5A5A5A5A, 4'hF);
        rd(5'd3);
        rd(5'd4);
        rd(5'd5);
        idle();
        idle();

        // clr with a read in flight, read during the sweep, then read back zero.
        wr(5'd8, 32'h6A6A6A6A, 4'hF);
        rd(5'd8);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, '0, '0);
        rd(5'd8);
        for (int i = 0; i < DEPTH + 2; i++) idle();
        rd(5'd8);
        chk("clr_zero", dout1, 32'h0);
        idle();

        // rst with a latency-2 read in flight.
        wr(5'd9, 32'h12345678, 4'hF);
        rd(5'd9);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < DEPTH + 1; i++) idle();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(0, 199);
            r  = (sel == 0);
            cl = (sel >= 1 && sel <= 3);
            e  = ($urandom_range(0, 7) != 0);
            v  = ($urandom_range(0, 5) != 0);
            w  = $urandom_range(0, 1) != 0;
            a  = AW'($urandom_range(0, 31));
            step(r, cl, e, v, w, a, DW'($urandom), 4'($urandom_range(0, 15)));
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
